// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit:
// FSM states, instruction classes, opcodes, ALU op codes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_WB_ALU,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILL
    } iclass_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [3:0] ALUOP_NONE  = 4'b0000;
    localparam logic [3:0] ALUOP_ADD   = 4'b0110;
    localparam logic [3:0] ALUOP_AND   = 4'b0011;
    localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
    localparam logic [3:0] ALUOP_BEQ   = 4'b0001;
    localparam logic [3:0] ALUOP_BLTZ  = 4'b1000;
    localparam logic [3:0] ALUOP_BGTZ  = 4'b1100;
    localparam logic [3:0] ALUOP_BGEZ  = 4'b1001;

    typedef enum logic [2:0] {
        BC_BEQ  = 3'd0,
        BC_BNE  = 3'd1,
        BC_BLTZ = 3'd2,
        BC_BGTZ = 3'd3,
        BC_BGEZ = 3'd4
    } bcond_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'd0,
        PCS_ALUOUT = 2'd1,
        PCS_JUMP   = 2'd2
    } pcsrc_e;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SHL = 2'd3
    } srcb_e;

    typedef struct packed {
        logic [3:0] aluop;
        logic       pc_write;
        logic       pc_write_cond;
        bcond_e     branch_cond;
        pcsrc_e     pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       alu_src_a;
        srcb_e      alu_src_b;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    // Moore control word for a state; fetch marks the strobes that mem_ready qualifies.
    function automatic ctrl_t state_ctrl(input state_e st, input iclass_e cls,
                                         input logic [3:0] dec_aluop, input bcond_e dec_bc);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.pc_source = PCS_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SHL;
                c.aluop     = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.aluop     = ALUOP_RTYPE;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = dec_aluop;
            end
            ST_WB_ALU: begin
                c.reg_write = 1'b1;
                c.reg_dst   = (cls == CLS_R);
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEM_WR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REGB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
                c.aluop         = dec_aluop;
                c.branch_cond   = dec_bc;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode decoder: instruction class, ALU op code and branch
// condition from the opcode and instr[16] (REGIMM bltz/bgez select).
module mc_opdecode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic       rt0_i,
    output iclass_e    cls_o,
    output logic [3:0] aluop_o,
    output bcond_e     bcond_o
);

    always_comb begin
        cls_o   = CLS_ILL;
        aluop_o = ALUOP_NONE;
        bcond_o = BC_BEQ;
        case (op_i)
            OP_RTYPE: begin
                cls_o   = CLS_R;
                aluop_o = ALUOP_RTYPE;
            end
            OP_ADDI: begin
                cls_o   = CLS_I;
                aluop_o = ALUOP_ADD;
            end
            OP_ANDI: begin
                cls_o   = CLS_I;
                aluop_o = ALUOP_AND;
            end
            OP_LW: begin
                cls_o   = CLS_LW;
                aluop_o = ALUOP_ADD;
            end
            OP_SW: begin
                cls_o   = CLS_SW;
                aluop_o = ALUOP_ADD;
            end
            OP_BEQ: begin
                cls_o   = CLS_BRANCH;
                aluop_o = ALUOP_BEQ;
                bcond_o = BC_BEQ;
            end
            OP_BNE: begin
                cls_o   = CLS_BRANCH;
                aluop_o = ALUOP_BEQ;
                bcond_o = BC_BNE;
            end
            OP_BGTZ: begin
                cls_o   = CLS_BRANCH;
                aluop_o = ALUOP_BGTZ;
                bcond_o = BC_BGTZ;
            end
            OP_REGIMM: begin
                cls_o   = CLS_BRANCH;
                aluop_o = rt0_i ? ALUOP_BGEZ : ALUOP_BLTZ;
                bcond_o = rt0_i ? BC_BGEZ : BC_BLTZ;
            end
            OP_J: begin
                cls_o = CLS_JUMP;
            end
            default: begin
                cls_o   = CLS_ILL;
                aluop_o = ALUOP_NONE;
                bcond_o = BC_BEQ;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM. Define MC_CTRL_MEM_WAIT_EN to let
// mem_ready stall FETCH/MEM_RD/MEM_WR; otherwise every access takes one cycle.
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       rt0,
    input  logic       mem_ready,
    output logic [3:0] aluop,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [2:0] branch_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       ill_op
);

    logic rdy;
`ifdef MC_CTRL_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    state_e     state_q, state_d;
    logic [6:0] opl_q, opl_d;
    ctrl_t      ctrl_q, ctrl_d, ctrl_o;
    iclass_e    cls;
    logic [3:0] dec_aluop;
    bcond_e     dec_bc;

    // The decoder sees the live IR only in DECODE; afterwards the latched copy.
    assign opl_d = (state_q == ST_DECODE) ? {op, rt0} : opl_q;

    mc_opdecode u_opdecode (
        .op_i    (opl_d[6:1]),
        .rt0_i   (opl_d[0]),
        .cls_o   (cls),
        .aluop_o (dec_aluop),
        .bcond_o (dec_bc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (rdy) state_d = ST_DECODE;
            ST_DECODE: begin
                case (cls)
                    CLS_R:          state_d = ST_EXEC_R;
                    CLS_I:          state_d = ST_EXEC_I;
                    CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
                    CLS_BRANCH:     state_d = ST_BRANCH;
                    CLS_JUMP:       state_d = ST_JUMP;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = (cls == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: if (rdy) state_d = ST_WB_MEM;
            ST_MEM_WR: if (rdy) state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
        ctrl_d = state_ctrl(state_d, cls, dec_aluop, dec_bc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            opl_q   <= '0;
            ctrl_q  <= state_ctrl(ST_FETCH, CLS_ILL, ALUOP_NONE, BC_BEQ);
        end else begin
            state_q <= state_d;
            opl_q   <= opl_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Control word is preloaded with FETCH on reset and held quiet while reset is high.
    assign ctrl_o = reset ? '0 : ctrl_q;

    assign aluop         = ctrl_o.aluop;
    assign ir_write      = ctrl_o.fetch & rdy;
    assign pc_write      = ctrl_o.pc_write | (ctrl_o.fetch & rdy);
    assign pc_write_cond = ctrl_o.pc_write_cond;
    assign branch_cond   = ctrl_o.branch_cond;
    assign pc_source     = ctrl_o.pc_source;
    assign i_or_d        = ctrl_o.i_or_d;
    assign mem_read      = ctrl_o.mem_read;
    assign mem_write     = ctrl_o.mem_write;
    assign alu_src_a     = ctrl_o.alu_src_a;
    assign alu_src_b     = ctrl_o.alu_src_b;
    assign reg_dst       = ctrl_o.reg_dst;
    assign reg_write     = ctrl_o.reg_write;
    assign mem_to_reg    = ctrl_o.mem_to_reg;
    assign ill_op        = ~reset & (state_q == ST_DECODE) & (cls == CLS_ILL);

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class cycle by cycle
// and checks the control outputs against hand-derived values.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset, rt0, mem_ready;
    logic [5:0] op;
    logic [3:0] aluop;
    logic       pc_write, pc_write_cond;
    logic [2:0] branch_cond;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst, reg_write, mem_to_reg, ill_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_control dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .rt0           (rt0),
        .mem_ready     (mem_ready),
        .aluop         (aluop),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_cond   (branch_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .ill_op        (ill_op)
    );

    localparam logic [5:0] O_R      = 6'b000000;
    localparam logic [5:0] O_REGIMM = 6'b000001;
    localparam logic [5:0] O_J      = 6'b000010;
    localparam logic [5:0] O_BEQ    = 6'b000100;
    localparam logic [5:0] O_BNE    = 6'b000101;
    localparam logic [5:0] O_BGTZ   = 6'b000111;
    localparam logic [5:0] O_ADDI   = 6'b001000;
    localparam logic [5:0] O_ANDI   = 6'b001100;
    localparam logic [5:0] O_LW     = 6'b100011;
    localparam logic [5:0] O_SW     = 6'b101011;
    localparam logic [5:0] O_BAD    = 6'b111111;

    // Strobe vector order: ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write, ill_op
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_IR   = 7'b1000000;
    localparam logic [6:0] S_PCW  = 7'b0100000;
    localparam logic [6:0] S_PCWC = 7'b0010000;
    localparam logic [6:0] S_MRD  = 7'b0001000;
    localparam logic [6:0] S_MWR  = 7'b0000100;
    localparam logic [6:0] S_RW   = 7'b0000010;
    localparam logic [6:0] S_ILL  = 7'b0000001;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    task automatic cyc(input logic [5:0] o, input logic r0, input logic rdy, input logic rst);
        @(posedge clk);
        #1;
        op        = o;
        rt0       = r0;
        mem_ready = rdy;
        reset     = rst;
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strb(input string tag, input logic [6:0] e);
        chk({tag, "_strobes"},
            8'({ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write, ill_op}), 8'(e));
    endtask

    task automatic chk_zero(input string tag);
        strb(tag, S_NONE);
        chk({tag, "_aluop"}, 8'(aluop), 8'h00);
        chk({tag, "_bcond"}, 8'(branch_cond), 8'h00);
        chk({tag, "_pcsrc"}, 8'(pc_source), 8'h00);
        chk({tag, "_srcb"}, 8'(alu_src_b), 8'h00);
        chk({tag, "_misc"}, 8'({i_or_d, alu_src_a, reg_dst, mem_to_reg}), 8'h00);
    endtask

    task automatic chk_fetch(input string tag, input logic done);
        strb(tag, done ? (S_IR | S_PCW | S_MRD) : S_MRD);
        chk({tag, "_aluop"}, 8'(aluop), 8'h06);
        chk({tag, "_srca"}, 8'(alu_src_a), 8'h00);
        chk({tag, "_srcb"}, 8'(alu_src_b), 8'h01);
        chk({tag, "_iord"}, 8'(i_or_d), 8'h00);
        chk({tag, "_pcsrc"}, 8'(pc_source), 8'h00);
    endtask

    task automatic chk_decode(input string tag, input logic ill);
        strb(tag, ill ? S_ILL : S_NONE);
        chk({tag, "_aluop"}, 8'(aluop), 8'h06);
        chk({tag, "_srca"}, 8'(alu_src_a), 8'h00);
        chk({tag, "_srcb"}, 8'(alu_src_b), 8'h03);
    endtask

    task automatic chk_exec(input string tag, input logic [3:0] ea, input logic [1:0] eb);
        strb(tag, S_NONE);
        chk({tag, "_aluop"}, 8'(aluop), 8'(ea));
        chk({tag, "_srca"}, 8'(alu_src_a), 8'h01);
        chk({tag, "_srcb"}, 8'(alu_src_b), 8'(eb));
    endtask

    task automatic chk_branch(input string tag, input logic [3:0] ea, input logic [2:0] ebc);
        strb(tag, S_PCWC);
        chk({tag, "_aluop"}, 8'(aluop), 8'(ea));
        chk({tag, "_bcond"}, 8'(branch_cond), 8'(ebc));
        chk({tag, "_pcsrc"}, 8'(pc_source), 8'h01);
        chk({tag, "_srca"}, 8'(alu_src_a), 8'h01);
        chk({tag, "_srcb"}, 8'(alu_src_b), 8'h00);
    endtask

    initial begin
        reset = 1'b1; op = O_R; rt0 = 1'b0; mem_ready = 1'b1;

        cyc(O_R, 0, 1, 1); chk_zero("rst_a");
        cyc(O_R, 0, 1, 1); chk_zero("rst_b");

        // R-type; IR is scrambled after DECODE to show the latched opcode is used
        cyc(O_R, 0, 1, 0);   chk_fetch("r_fetch", 1'b1);
        cyc(O_R, 0, 1, 0);   chk_decode("r_dec", 1'b0);
        cyc(O_BAD, 1, 1, 0); chk_exec("r_exec", 4'h2, 2'd0);
        cyc(O_BAD, 1, 1, 0); strb("r_wb", S_RW);
        chk("r_wb_regdst", 8'(reg_dst), 8'h01);
        chk("r_wb_memtoreg", 8'(mem_to_reg), 8'h00);

        cyc(O_BAD, 0, 1, 0); chk_fetch("andi_fetch", 1'b1);
        cyc(O_ANDI, 0, 1, 0); chk_decode("andi_dec", 1'b0);
        cyc(O_R, 0, 1, 0);    chk_exec("andi_exec", 4'h3, 2'd2);
        cyc(O_R, 0, 1, 0);    strb("andi_wb", S_RW);
        chk("andi_wb_regdst", 8'(reg_dst), 8'h00);

        cyc(O_R, 0, 1, 0);    chk_fetch("addi_fetch", 1'b1);
        cyc(O_ADDI, 0, 1, 0); chk_decode("addi_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0);  chk_exec("addi_exec", 4'h6, 2'd2);
        cyc(O_BAD, 0, 1, 0);  strb("addi_wb", S_RW);
        chk("addi_wb_regdst", 8'(reg_dst), 8'h00);

        cyc(O_BAD, 0, 1, 0); chk_fetch("lw_fetch", 1'b1);
        cyc(O_LW, 0, 1, 0);  chk_decode("lw_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0); chk_exec("lw_addr", 4'h6, 2'd2);
`ifdef MC_CTRL_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            cyc(O_BAD, 0, 0, 0); strb("lw_rd_wait", S_MRD);
            chk("lw_rd_wait_iord", 8'(i_or_d), 8'h01);
        end
        cyc(O_BAD, 0, 1, 0); strb("lw_rd", S_MRD);
`else
        cyc(O_BAD, 0, 0, 0); strb("lw_rd", S_MRD);
`endif
        chk("lw_rd_iord", 8'(i_or_d), 8'h01);
        cyc(O_BAD, 0, 1, 0); strb("lw_wb", S_RW);
        chk("lw_wb_memtoreg", 8'(mem_to_reg), 8'h01);
        chk("lw_wb_regdst", 8'(reg_dst), 8'h00);

        cyc(O_BAD, 0, 1, 0); chk_fetch("sw_fetch", 1'b1);
        cyc(O_SW, 0, 1, 0);  chk_decode("sw_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0); chk_exec("sw_addr", 4'h6, 2'd2);
`ifdef MC_CTRL_MEM_WAIT_EN
        cyc(O_BAD, 0, 0, 0); strb("sw_wr_wait", S_MWR);
`endif
        cyc(O_BAD, 0, 1, 0); strb("sw_wr", S_MWR);
        chk("sw_wr_iord", 8'(i_or_d), 8'h01);

        cyc(O_BAD, 0, 1, 0);    chk_fetch("bltz_fetch", 1'b1);
        cyc(O_REGIMM, 0, 1, 0); chk_decode("bltz_dec", 1'b0);
        cyc(O_REGIMM, 1, 1, 0); chk_branch("bltz", 4'h8, 3'd2);
        cyc(O_BAD, 0, 1, 0);    chk_fetch("bgez_fetch", 1'b1);
        cyc(O_REGIMM, 1, 1, 0); chk_decode("bgez_dec", 1'b0);
        cyc(O_REGIMM, 0, 1, 0); chk_branch("bgez", 4'h9, 3'd4);
        cyc(O_BAD, 0, 1, 0);    chk_fetch("beq_fetch", 1'b1);
        cyc(O_BEQ, 0, 1, 0);    chk_decode("beq_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0);    chk_branch("beq", 4'h1, 3'd0);
        cyc(O_BAD, 0, 1, 0);    chk_fetch("bne_fetch", 1'b1);
        cyc(O_BNE, 0, 1, 0);    chk_decode("bne_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0);    chk_branch("bne", 4'h1, 3'd1);
        cyc(O_BAD, 0, 1, 0);    chk_fetch("bgtz_fetch", 1'b1);
        cyc(O_BGTZ, 0, 1, 0);   chk_decode("bgtz_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0);    chk_branch("bgtz", 4'hC, 3'd3);

        cyc(O_BAD, 0, 1, 0); chk_fetch("j_fetch", 1'b1);
        cyc(O_J, 0, 1, 0);   chk_decode("j_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0); strb("j_jump", S_PCW);
        chk("j_jump_pcsrc", 8'(pc_source), 8'h02);

        cyc(O_R, 0, 1, 0);   chk_fetch("ill_fetch", 1'b1);
        cyc(O_BAD, 0, 1, 0); chk_decode("ill_dec", 1'b1);
        cyc(O_R, 0, 0, 0);   chk_fetch("ill_refetch_nordy", ~WAIT_EN);
`ifdef MC_CTRL_MEM_WAIT_EN
        cyc(O_R, 0, 1, 0);   chk_fetch("ill_refetch_rdy", 1'b1);
`endif
        cyc(O_BAD, 0, 1, 0); chk_decode("ill_dec2", 1'b1);

        // lw abandoned by a two-cycle reset entering MEM_RD
        cyc(O_R, 0, 1, 0);   chk_fetch("rlw_fetch", 1'b1);
        cyc(O_LW, 0, 1, 0);  chk_decode("rlw_dec", 1'b0);
        cyc(O_BAD, 0, 1, 0); chk_exec("rlw_addr", 4'h6, 2'd2);
        cyc(O_BAD, 0, 0, 1); chk_zero("rlw_rst_a");
        cyc(O_BAD, 0, 1, 1); chk_zero("rlw_rst_b");
        cyc(O_BAD, 0, 1, 0); chk_fetch("rlw_after", 1'b1);
        cyc(O_BAD, 0, 1, 0); chk_decode("rlw_dec_after", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath, directly upstream of the ALU control decoder. It decodes the instruction opcode and steps a fetch/decode/execute/memory/writeback state machine. Each cycle it drives the datapath enables, the mux selects, and the 4-bit ALU operation code that the ALU control decoder turns into the ALU function. Memory accesses stall on a ready handshake.

## Interface
- Parameters: none.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- op  in  6  instruction opcode, instr[31:26], from the instruction register.
- rt0  in  1  instr[16]; selects bltz (0) or bgez (1) under REGIMM.
- mem_ready  in  1  memory completed the current access this cycle.
- aluop  out  4  ALU operation code; aluop[3]..aluop[0] map to decoder inputs aluop0..aluop3.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the datapath branch condition is true.
- branch_cond  out  3  condition select: 0 beq, 1 bne, 2 bltz, 3 bgtz, 4 bgez.
- pc_source  out  2  PC source: 0 ALU result, 1 ALUOut register, 2 jump target.
- i_or_d, mem_read, mem_write, ir_write  out  1 each  memory address select (1 = data address) and memory/IR strobes.
- alu_src_a  out  1  ALU A source: 0 PC, 1 register A.
- alu_src_b  out  2  ALU B source: 0 register B, 1 constant 4, 2 sign-extended immediate, 3 shifted immediate.
- reg_dst, reg_write, mem_to_reg  out  1 each  register-file controls.
- ill_op  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- Reset: state FETCH. All outputs are 0, aluop is 0000, and branch_cond is 0 until the first FETCH cycle after reset is released.
- aluop codes:
  - 0110: add (fetch, decode, lw, sw, addi).
  - 0011: andi.
  - 0010: R-type.
  - 0001: beq/bne.
  - 1000: bltz.
  - 1100: bgtz.
  - 1001: bgez.
- FETCH:
  - Drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, aluop=0110.
  - When mem_ready=1, also drive ir_write=1 and pc_write=1 with pc_source=0, then go to DECODE.
  - Otherwise stay in FETCH with the strobes held.
- DECODE:
  - Drive alu_src_a=0, alu_src_b=3, aluop=0110 (branch target into ALUOut).
  - Next state by op:
    - 000000 → EXEC_R.
    - 001000 or 001100 → EXEC_I.
    - 100011 or 101011 → MEM_ADDR.
    - 000100, 000101, 000111, or 000001 → BRANCH.
    - 000010 → JUMP.
    - Any other opcode → FETCH with ill_op=1.
- EXEC_R: alu_src_a=1, alu_src_b=0, aluop=0010 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=2, aluop=0110 (addi) or 0011 (andi) → WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, aluop=0110 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: i_or_d=1, mem_read=1; held until mem_ready=1, then → WB_MEM.
- MEM_WR: i_or_d=1, mem_write=1; held until mem_ready=1, then → FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- BRANCH:
  - Drive alu_src_a=1, alu_src_b=0, pc_write_cond=1, pc_source=1.
  - aluop and branch_cond come from the opcode; REGIMM uses rt0 to pick bltz or bgez.
  - Next state → FETCH.
- JUMP: pc_write=1, pc_source=2 → FETCH.
- Latched opcode: op and rt0 are latched into an internal register during DECODE. Later states use the latched copy, so IR changes after DECODE have no effect.

## Timing
- Outputs are a Moore function of the state register plus the latched opcode. The exceptions are the FETCH strobes ir_write and pc_write, which are qualified combinationally by mem_ready.
- Cycle counts with zero wait states:
  - R-type, addi, andi: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - jump: 3.
  - illegal opcode: 2.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset asserted in any state forces FETCH on the next edge; an in-progress access is abandoned with no write strobe.

## Configuration
- MC_CTRL_MEM_WAIT_EN:
  - Defined: mem_ready stalls FETCH, MEM_RD and MEM_WR as described above.
  - Undefined: mem_ready is ignored and treated as 1, so every memory state lasts exactly one cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (11 states, 4-bit encoding);
  - the opcode constants;
  - the aluop constants;
  - the branch_cond and pc_source/alu_src_b encodings.
- Sub-module mc_opdecode (combinational): maps op and rt0 to an instruction class, an aluop, and a branch_cond. mc_control instantiates it once.

## Test plan
- Reset held 2 cycles mid-MEM_RD → next cycle state FETCH, mem_read=1, reg_write=0, all other strobes 0.
- R-type (op=000000), mem_ready tied 1 → cycles: FETCH ir_write=1, DECODE, EXEC_R aluop=0010, WB_ALU reg_write=1 reg_dst=1; back in FETCH at cycle 5.
- lw (op=100011) with mem_ready low 3 cycles in MEM_RD → MEM_RD lasts 4 cycles, WB_MEM mem_to_reg=1, total 8 cycles.
- REGIMM op=000001: rt0=0 → BRANCH aluop=1000, branch_cond=2; rt0=1 → aluop=1001, branch_cond=4; pc_write_cond=1 for one cycle.
- andi (op=001100) → EXEC_I aluop=0011, alu_src_b=2; addi (op=001000) → aluop=0110.
- Illegal op=111111 → ill_op=1 for exactly one cycle in DECODE, no reg_write/mem_write, FETCH next; repeat with MC_CTRL_MEM_WAIT_EN undefined and mem_ready=0 → fetch still completes in 1 cycle.
